// File: rtl/sprite_pkg.sv
// Shared widths, FSM state and command record for the sprite programming path.
package sprite_pkg;

    localparam int unsigned SPRITE_ID_W = 6;
    localparam int unsigned COORD_W     = 8;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned CMD_W       = SPRITE_ID_W + 2 * COORD_W + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } prog_state_e;

    typedef struct packed {
        logic [SPRITE_ID_W-1:0] id;
        logic [COORD_W-1:0]     x;
        logic [COORD_W-1:0]     y;
        logic [ADDR_W-1:0]      addr;
    } sprite_cmd_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Command queue; ready is registered and a full queue ignores pushes even on a pop edge.
module sprite_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             ready_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ready_q;
    assign do_pop  = pop_i & (count_q != '0);
    assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(DEPTH));
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sprite_programmer.sv
// Drains queued sprite updates onto the programming bus during vblank
// with a setup / one-cycle strobe / hold sequence.
module sprite_programmer
    import sprite_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES  = 1,
    parameter logic [7:0]  VIS_ROWS     = 8'd120
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_id,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [15:0] cmd_address,
    input  logic [7:0]  screenY,
    output logic [5:0]  requested_sprite_id,
    output logic [7:0]  setx,
    output logic [7:0]  sety,
    output logic [15:0] set_address,
    output logic        program_active,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;

    prog_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pa_q;
    sprite_cmd_t      bus_q;
    sprite_cmd_t      push_cmd;
    sprite_cmd_t      head_cmd;
    logic             fifo_empty;
    logic             pop_c;

    assign push_cmd = '{id: cmd_id, x: cmd_x, y: cmd_y, addr: cmd_address};
    assign pop_c    = (state_q == ST_HOLD) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    sprite_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .clear   (clear),
        .push_i  (cmd_valid),
        .data_i  (push_cmd),
        .pop_i   (pop_c),
        .data_o  (head_cmd),
        .empty_o (fifo_empty),
        .ready_o (cmd_ready)
    );

    // Once started a transaction runs to completion regardless of screenY.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pa_q    <= 1'b0;
            bus_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty && (screenY >= VIS_ROWS)) begin
                        bus_q   <= head_cmd;
                        cnt_q   <= '0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                        pa_q    <= 1'b1;
                        state_q <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    pa_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (pop_c) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign program_active      = pa_q;
    assign busy                = !fifo_empty || (state_q != ST_IDLE);
    assign requested_sprite_id = bus_q.id;
    assign setx                = bus_q.x;
    assign sety                = bus_q.y;
    assign set_address         = bus_q.addr;

endmodule

// File: doc/sprite_programmer.md
SPRITE_PROGRAMMER -- requirements
Module: sprite_programmer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two), command queue depth.
REQ-002 SHALL have parameter SETUP_CYCLES, default 1 (range 1..15), cycles the bus is stable before program_active rises.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1 (range 1..15), cycles the bus is held after program_active falls.
REQ-004 SHALL have parameter VIS_ROWS, default 8'd120, first non-visible screenY row.
REQ-005 SHALL have a single clock and an asynchronous active-high reset: clk, clear.
REQ-006 clk  in  1  system clock; all state changes on posedge.
REQ-007 clear  in  1  asynchronous active-high reset.
REQ-008 cmd_valid  in  1  command offered.
REQ-009 cmd_ready  out  1  queue can accept a command.
REQ-010 cmd_id  in  6  target sprite id (0..63).
REQ-011 cmd_x  in  8  new sprite X.
REQ-012 cmd_y  in  8  new sprite Y.
REQ-013 cmd_address  in  16  new sprite pixel base address.
REQ-014 screenY  in  8  current raster row.
REQ-015 requested_sprite_id  out  6  programming bus: target id.
REQ-016 setx  out  8  programming bus: X.
REQ-017 sety  out  8  programming bus: Y.
REQ-018 set_address  out  16  programming bus: base address.
REQ-019 program_active  out  1  strobe; sprites latch on its rising edge.
REQ-020 busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-021 Command SHALL be accepted on a posedge with cmd_valid && cmd_ready; cmd_ready SHALL equal !full, registered, with no combinational path from cmd_valid or the pop.
REQ-022 When the FIFO is full, cmd_valid SHALL be ignored and the FIFO contents SHALL be unchanged, even if a pop occurs on the same edge.
REQ-023 A push and a pop on the same edge with the FIFO not full SHALL both take effect, with count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 FSM states SHALL be IDLE, SETUP, STROBE, HOLD.
REQ-025 IDLE -> SETUP SHALL occur when the FIFO is non-empty and screenY >= VIS_ROWS; on that edge the head entry SHALL be loaded into the bus registers.
REQ-026 SETUP SHALL last SETUP_CYCLES cycles with program_active=0, then go to STROBE.
REQ-027 STROBE SHALL last exactly 1 cycle with program_active=1, then go to HOLD.
REQ-028 HOLD SHALL last HOLD_CYCLES cycles with program_active=0; on its final edge the FIFO SHALL pop and the FSM SHALL return to IDLE.
REQ-029 program_active SHALL be a registered output, 1 only in STROBE.
REQ-030 Bus outputs SHALL be registered and SHALL not change from SETUP entry to HOLD exit.
REQ-031 In IDLE, bus outputs SHALL hold the last issued values.
REQ-032 Latency: with an empty FIFO and screenY >= VIS_ROWS, a command accepted at edge E0 SHALL produce a program_active rise at edge E0+1+SETUP_CYCLES.
REQ-033 A transaction SHALL be atomic: screenY dropping below VIS_ROWS mid-transaction SHALL NOT abort it; the next transaction SHALL wait for the next vblank.
REQ-034 Minimum spacing between program_active rises SHALL be SETUP_CYCLES+HOLD_CYCLES+2 cycles.
REQ-035 Commands SHALL be issued in acceptance order; duplicate ids SHALL each be issued.

Reset
REQ-036 On clear, the following SHALL take effect asynchronously: state=IDLE, FIFO empty, program_active=0, busy=0, cmd_ready=1, and all bus outputs=0.
REQ-037 Reset during STROBE SHALL drop program_active immediately; the in-flight command SHALL be discarded.

Structure
REQ-038 Package sprite_pkg SHALL hold SPRITE_ID_W=6, COORD_W=8, ADDR_W=16, the FSM state type and the command record type.
REQ-039 The queue SHALL be a separate sub-module, sprite_cmd_fifo, parameterised by depth and width (38 bits).

Verification
REQ-040 Reset, screenY=200; push id=5, x=10, y=20, addr=16'h0100 at E0 -> program_active=1 during cycle E2→E3 only; bus=5/10/20/0100 from E1 through E3+1.
REQ-041 screenY=50; push 1 command -> no strobe; set screenY=120 -> strobe after 2 further edges.
REQ-042 Push 5 commands back-to-back with screenY=50 -> cmd_ready=0 after the 4th; the 5th is dropped; after vblank, exactly 4 strobes in order, 4 cycles apart.
REQ-043 screenY=200; queue 2 commands; drop screenY to 0 during SETUP of the first -> first completes; second waits until screenY>=120.
REQ-044 Assert clear while program_active=1 -> program_active=0 within the same cycle; busy=0, cmd_ready=1, and no later strobe for the queued commands.
REQ-045 Full FIFO, simultaneous pop edge with cmd_valid=1 -> push ignored; count=3 afterwards; cmd_ready=1 on the next cycle.
